// File: rtl/sine_lut.sv
// Quarter-wave sine ROM: maps a first-quadrant phase index to an unsigned amplitude (MSB always 0).
// Define SINE_LUT_COMB_EN for a zero-latency combinational output; the default build registers the output.
module sine_lut #(
    parameter int AW  = 13,
    parameter int DW  = 16,
    parameter int AMP = 32767
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] v,
    output logic [DW-1:0] sv
);

    localparam int  DEPTH   = 1 << AW;
    localparam real HALF_PI = 1.57079632679489661923;

    // Table entry from a Taylor series, so every entry folds to a constant at elaboration.
    // The series runs to x^25, well below double precision over [0, pi/2].
    function automatic logic [DW-1:0] f_entry(input int idx);
        real x;
        real term;
        real acc;
        int  val;
        x    = HALF_PI * (real'(idx) + 0.5) / real'(DEPTH);
        term = x;
        acc  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        val = $rtoi(real'(AMP) * acc + 0.5);
        if (val > AMP) val = AMP;
        if (val < 0)   val = 0;
        return val[DW-1:0];
    endfunction

    logic [DW-1:0] w_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [DW-1:0] C_ENTRY = f_entry(gi);
        assign w_rom[gi] = C_ENTRY;
    end

    logic [DW-1:0] w_lookup;

    // NOTE: w_lookup gets a value on every path, so no latch is inferred.
    always_comb begin
        w_lookup = w_rom[v];
        if ($isunknown(v)) w_lookup = '0;
    end

`ifdef SINE_LUT_COMB_EN

    logic w_unused_clk;
    assign w_unused_clk = clk;

    assign sv = rst ? '0 : w_lookup;

`else

    logic [DW-1:0] r_sv;

    // NOTE: non-blocking assignment for state; only the output register is reset, the ROM holds constants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sv <= '0;
        else     r_sv <= w_lookup;
    end

    assign sv = r_sv;

`endif

endmodule

// File: tb/tb_sine_lut.sv
// Self-checking bench for sine_lut: a real-arithmetic model of the table, a per-cycle compare
// process, and directed vectors with hand-computed values.
module tb_sine_lut;

    localparam int  AW    = 13;
    localparam int  DW    = 16;
    localparam int  AMP   = 32767;
    localparam int  DEPTH = 1 << AW;
    localparam real PI    = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] v   = '0;
    logic [DW-1:0] sv;

    int n_tests = 0;
    int n_fail  = 0;

    int  tbl [DEPTH];
    int  exp_sv = 0;
    bit  cmp_en = 1'b0;

    sine_lut #(.AW(AW), .DW(DW), .AMP(AMP)) dut (
        .clk (clk),
        .rst (rst),
        .v   (v),
        .sv  (sv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (v=%0d rst=%0b t=%0t)", name, act, req, v, rst, $time);
        end
    endtask

    // Expected output: the table value of the index seen at the last edge (registered),
    // or of the current index (combinational); zero whenever reset is active.
`ifdef SINE_LUT_COMB_EN
    always_comb exp_sv = rst ? 0 : tbl[v];
`else
    always @(posedge clk or posedge rst) begin
        if (rst) exp_sv = 0;
        else     exp_sv = tbl[v];
    end
`endif

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stream", sv, exp_sv);
            check("msb_zero", sv[DW-1], 0);
        end
    end

    task automatic step(input int idx);
        v = idx[AW-1:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int prev;
        for (int i = 0; i < DEPTH; i++)
            tbl[i] = $rtoi(real'(AMP) * $sin((PI / 2.0) * (real'(i) + 0.5) / real'(DEPTH)) + 0.5);

        // Pin the model itself to hand-computed values.
        check("model_t0", tbl[0], 3);
        check("model_t8191", tbl[8191], 32767);
        check("model_t4096", tbl[4096], 23172);
        check("model_t2048", tbl[2048], 12542);

        // Reset held: output stays zero across clock edges.
        v = 13'd8191;
        @(negedge clk);
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_hold", sv, 0);
        end

        // Release and directed lookups.
        rst = 1'b0;
        step(0);
        check("v0", sv, 3);
        step(8191);
        check("v8191", sv, 16'h7FFF);
        step(4096);
        check("v4096", sv, 23172);
        step(2048);
        check("v2048_tol", (sv >= 12541 && sv <= 12543), 1);

`ifdef SINE_LUT_COMB_EN
        // Combinational mode: the value follows v without a clock edge.
        v = 13'd8191;
        #1;
        check("comb_8191", sv, 32767);
        v = 13'd0;
        #1;
        check("comb_0", sv, 3);
        rst = 1'b1;
        #1;
        check("comb_rst", sv, 0);
        rst = 1'b0;
        #1;
        check("comb_release", sv, 3);
        @(negedge clk);
`else
        // Registered mode: a new index does not reach the output before the edge.
        v = 13'd100;
        #1;
        check("latency_hold", sv, tbl[2048]);
        @(posedge clk);
        @(negedge clk);
        check("latency_load", sv, tbl[100]);
`endif

        // Full sweep: exact match (compare process), monotonic, MSB clear.
        prev = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(i);
            if (i > 0) check("monotonic", (sv >= prev), 1);
            prev = sv;
            if (i == 3000) begin
                // Reset pulse mid-sweep: output clears at once and the sweep resumes.
                @(posedge clk);
                #1 rst = 1'b1;
                #1 check("rst_async", sv, 0);
                @(negedge clk);
                check("rst_pending_discarded", sv, 0);
                rst = 1'b0;
                v = 13'd3001;
                @(posedge clk);
                @(negedge clk);
                check("rst_resume", sv, tbl[3001]);
                prev = 0;
            end
        end
        check("sweep_end", sv, 32767);

        // Varying-index burst with alternating extremes.
        step(8191);
        step(0);
        check("burst_0", sv, 3);
        step(5000);
        check("burst_5000", sv, tbl[5000]);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
